// File: rtl/pitch_out_filter.sv
// Moving-average low-pass on pitch-shift output samples, with a valid/ack hold
// handshake toward the codec side and a sticky overrun flag.
module pitch_out_filter #(
  parameter int unsigned TAPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_val,
  input  logic        bypass,
  output logic [31:0] out_data,
  output logic        out_val,
  input  logic        out_ack,
  output logic        overrun
);

  localparam int unsigned LOG2 = $clog2(TAPS);
  localparam int unsigned SW   = 32 + LOG2;

  logic [31:0]   hist_q [TAPS];
  logic [SW-1:0] sum_q, sum_d;
  logic [31:0]   raw_q;
  logic          byp_q;
  logic          s1_val_q;

  logic [31:0]   out_data_q, out_data_d;
  logic          out_val_q, out_val_d;
  logic          overrun_q, overrun_d;

  logic [SW-1:0] in_ext, old_ext;

  // Sum is wide enough for TAPS full-scale samples, so it never wraps.
  always_comb begin
    in_ext  = {{LOG2{in_data[31]}}, in_data};
    old_ext = {{LOG2{hist_q[TAPS-1][31]}}, hist_q[TAPS-1]};
    sum_d   = sum_q;
    if (in_val) begin
      sum_d = sum_q + in_ext - old_ext;
    end
  end

  // A fresh result always loads; losing an unacked one marks overrun.
  always_comb begin
    out_data_d = out_data_q;
    out_val_d  = out_val_q;
    overrun_d  = overrun_q;
    if (s1_val_q) begin
      out_data_d = byp_q ? raw_q : sum_q[LOG2 +: 32];
      out_val_d  = 1'b1;
      if (out_val_q && !out_ack) begin
        overrun_d = 1'b1;
      end
    end else if (out_val_q && out_ack) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_q[i] <= '0;
      end
      sum_q      <= '0;
      raw_q      <= '0;
      byp_q      <= 1'b0;
      s1_val_q   <= 1'b0;
      out_data_q <= '0;
      out_val_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (in_val) begin
        hist_q[0] <= in_data;
        for (int i = 1; i < int'(TAPS); i++) begin
          hist_q[i] <= hist_q[i-1];
        end
        raw_q <= in_data;
        byp_q <= bypass;
      end
      sum_q      <= sum_d;
      s1_val_q   <= in_val;
      out_data_q <= out_data_d;
      out_val_q  <= out_val_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_data = out_data_q;
  assign out_val  = out_val_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_pitch_out_filter.sv
// Directed bench for pitch_out_filter: averaging, negatives, bypass, overrun,
// same-edge ack/load and mid-flight reset.
module tb_pitch_out_filter;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_val;
  logic        bypass;
  logic [31:0] out_data;
  logic        out_val;
  logic        out_ack;
  logic        overrun;

  int checks;
  int failures;

  pitch_out_filter #(.TAPS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_val   (in_val),
    .bypass   (bypass),
    .out_data (out_data),
    .out_val  (out_val),
    .out_ack  (out_ack),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    in_val = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Strobe one sample; returns on the negedge after the output edge (t+2).
  task automatic strobe(input logic [31:0] d, input logic byp);
    @(negedge clk);
    in_data = d;
    bypass  = byp;
    in_val  = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] exp_v;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_data  = '0;
    in_val   = 1'b0;
    bypass   = 1'b0;
    out_ack  = 1'b1;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_out_val", {31'd0, out_val}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // T1: ramp-up of a constant 1000 with latency checks
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_data = 32'd1000;
      bypass  = 1'b0;
      in_val  = 1'b1;
      @(negedge clk);
      in_val = 1'b0;
      check("t1_val_t1", {31'd0, out_val}, 32'd0);
      @(negedge clk);
      exp_v = (k >= 8) ? 32'd1000 : 32'(k * 125);
      check("t1_val_t2", {31'd0, out_val}, 32'd1);
      check("t1_data", out_data, exp_v);
    end

    // T2: negative floor, then full-scale negative without overflow
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      strobe(-32'sd9, 1'b0);
      if (k == 1) check("t2_first_neg", out_data, -32'sd2);
    end
    check("t2_eighth_neg", out_data, -32'sd9);
    do_reset();
    for (int k = 1; k <= 8; k++) strobe(32'h8000_0000, 1'b0);
    check("t2_min_full", out_data, 32'h8000_0000);

    // T3: bypass then filtered including the bypassed sample
    do_reset();
    strobe(32'h1234_5678, 1'b1);
    check("t3_bypass", out_data, 32'h1234_5678);
    strobe(32'h0, 1'b0);
    check("t3_filtered", out_data, 32'h0246_8ACF);

    // T4: no ack, second result overwrites and sets sticky overrun
    do_reset();
    out_ack = 1'b0;
    strobe(32'd800, 1'b0);
    check("t4_first", out_data, 32'd100);
    check("t4_no_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    strobe(32'd800, 1'b0);
    check("t4_val_held", {31'd0, out_val}, 32'd1);
    check("t4_latest", out_data, 32'd200);
    check("t4_ovr", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    out_ack = 1'b1;
    @(negedge clk);
    check("t4_acked", {31'd0, out_val}, 32'd0);
    check("t4_ovr_sticky", {31'd0, overrun}, 32'd1);
    do_reset();
    @(negedge clk);
    check("t4_ovr_rst", {31'd0, overrun}, 32'd0);

    // T5: ack on the same edge a new result loads
    out_ack = 1'b0;
    @(negedge clk);
    in_data = 32'd80;
    bypass  = 1'b0;
    in_val  = 1'b1;
    @(negedge clk);
    in_data = 32'd160;
    @(negedge clk);
    in_val = 1'b0;
    check("t5_first", out_data, 32'd10);
    out_ack = 1'b1;
    @(negedge clk);
    check("t5_val_kept", {31'd0, out_val}, 32'd1);
    check("t5_new_data", out_data, 32'd30);
    check("t5_no_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    check("t5_cleared", {31'd0, out_val}, 32'd0);

    // T6: reset one cycle after in_val kills the in-flight sample
    do_reset();
    @(negedge clk);
    in_data = 32'd5000;
    in_val  = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_no_val", {31'd0, out_val}, 32'd0);
    @(negedge clk);
    check("t6_no_val2", {31'd0, out_val}, 32'd0);
    check("t6_data0", out_data, 32'd0);
    strobe(32'd800, 1'b0);
    check("t6_next", out_data, 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
